seq_chunk_adder: RTL and testbench
==================================

# seq_chunk_adder

Parametrised multi-cycle adder/subtractor that adds two WIDTH-bit operands CHUNK bits per clock, using a CHUNK-bit ripple-carry slice and a registered carry between slices. It is the sequential, width-generic successor to the team's 4-bit ripple-carry adder. It trades latency for a short critical path. Operands are accepted and results delivered over valid/ready handshakes, so it drops into the datapath between an operand source and a result consumer.

## Interface
- WIDTH, 32: operand/result width in bits; must be a positive multiple of CHUNK, otherwise elaboration fails.
- CHUNK, 4: bits added per cycle; N = WIDTH/CHUNK is the number of compute cycles.
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operand transaction offered.
- in_ready  out  1  block can accept operands; high only in IDLE.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- cin  in  1  carry-in (add) or borrow-in (sub).
- sub  in  1  0: A+B+cin; 1: A-B-cin.
- out_valid  out  1  result available; held until consumed.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  carry out of MSB (sub: 1 = no borrow).
- ovf  out  1  two's-complement signed overflow.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid && in_ready: latch A, B' = sub ? ~in_b : in_b, carry = sub ? ~cin : cin; clear chunk counter; go RUN.
- RUN: in_ready=0, out_valid=0. Each cycle adds chunk k of A and B' plus carry via the CHUNK-bit RCA slice. It writes result bits [k*CHUNK +: CHUNK], updates carry, and increments k. After chunk N-1: cout = final carry; ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1; go DONE.
- DONE: out_valid=1; sum/cout/ovf stable. On out_ready, go IDLE. in_valid is ignored in DONE and RUN; there is no overlap of transactions.
- Inputs in_a/in_b/cin/sub are sampled only at the acceptance edge; later changes have no effect.
- cin/sub combinations: sub=1, cin=1 computes A-B-1.

## Timing
- Reset (synchronous): on a rising edge with reset=1, state←IDLE, k←0, sum←0, cout←0, ovf←0, out_valid←0. in_ready reads 1 after that edge. A handshake offered in the same cycle as reset is dropped.
- Reset mid-RUN or in DONE: the transaction is aborted with no partial result. Reset values hold from the next cycle.
- Latency: the acceptance edge is E0. Chunks are computed on edges E1..EN. out_valid is high after EN, which is N cycles after acceptance. With CHUNK=WIDTH, N=1.
- Throughput: one result per N+2 cycles minimum (accept, N compute, consume edge), with out_ready held high.
- Backpressure: if out_ready=0, DONE holds indefinitely and outputs do not change.
- sum bits for chunks not yet computed are undefined to consumers until out_valid=1. The implementation clears them at acceptance.

## Test plan
Bench parameters are WIDTH=8, CHUNK=4, N=2, and clock period 20 ns unless noted.
- Add with carry-in: A=0x3D, B=0x28, cin=1, sub=0 -> out_valid exactly 2 cycles after acceptance; sum=0x66, cout=0, ovf=0.
- Wrap and overflow: A=0xFF, B=0x01, add -> sum=0x00, cout=1, ovf=0. Then A=0x7F, B=0x01, add -> sum=0x80, cout=0, ovf=1.
- Subtract: A=0x05, B=0x07, cin=0, sub=1 -> sum=0xFE, cout=0, ovf=0. Then A=0x80, B=0x01, sub=1 -> sum=0x7F, cout=1, ovf=1.
- Backpressure/isolation: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands -> sum stable, in_ready=0, no new acceptance. Raise out_ready -> IDLE next edge, and the new operands are accepted only then.
- Reset mid-operation: assert reset for one edge during RUN (after chunk 0) -> next cycle state IDLE, out_valid=0, sum=0x00, in_ready=1. The following A=0x12, B=0x34 add yields 0x46.
- Parameter sweep: WIDTH=32 with CHUNK=4, 8, and 32 -> latency 8, 4, and 1 cycles. Random 1000 vectors per config match the reference model for (A±B±cin) mod 2^32, cout, and ovf.

Source files
------------

// File: rtl/seq_chunk_adder_if.sv
// Operand/result handshake bundle for seq_chunk_adder.
// The master drives operands and result acceptance. The slave is the adder.
interface seq_chunk_adder_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output in_valid, in_a, in_b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );

   modport slave (
      input  in_valid, in_a, in_b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
endinterface

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per clock through one ripple slice,
// with a registered carry between slices and valid/ready handshakes on both sides.
module seq_chunk_adder #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 4
) (
   input logic              clock,
   input logic              reset,
   seq_chunk_adder_if.slave bus
);
   localparam int N  = WIDTH / CHUNK;
   localparam int KW = (N > 1) ? $clog2(N) : 1;

   generate
      if (CHUNK < 1 || WIDTH < CHUNK || (WIDTH % CHUNK) != 0) begin : g_bad_params
         $error("seq_chunk_adder: WIDTH must be a positive multiple of CHUNK");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, b_q, sum_q;
   logic             carry_q, cout_q, ovf_q;
   logic [KW-1:0]    k_q;
   logic [CHUNK-1:0] a_c, b_c, s_c;
   logic             cy, cy_msb, last;

   assign last = (k_q == KW'(N - 1));

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.in_valid)  state_d = RUN;
         RUN:     if (last)          state_d = DONE;
         DONE:    if (bus.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready  = (state_q == IDLE);
      bus.out_valid = (state_q == DONE);
   end

   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;
   assign bus.ovf  = ovf_q;

   // Ripple slice over chunk k; cy_msb ends as the carry into the slice's top bit,
   // which on the last chunk is the carry into bit WIDTH-1.
   always_comb begin
      a_c    = '0;
      b_c    = '0;
      s_c    = '0;
      cy     = carry_q;
      cy_msb = carry_q;
      for (int unsigned j = 0; j < N; j++) begin
         if (k_q == KW'(j)) begin
            a_c = a_q[j*CHUNK +: CHUNK];
            b_c = b_q[j*CHUNK +: CHUNK];
         end
      end
      for (int unsigned i = 0; i < CHUNK; i++) begin
         cy_msb = cy;
         s_c[i] = a_c[i] ^ b_c[i] ^ cy;
         cy     = (a_c[i] & b_c[i]) | (cy & (a_c[i] ^ b_c[i]));
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         k_q     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  // Subtraction runs as A + ~B + ~borrow through the same slice.
                  a_q     <= bus.in_a;
                  b_q     <= bus.sub ? ~bus.in_b : bus.in_b;
                  carry_q <= bus.sub ^ bus.cin;
                  k_q     <= '0;
                  sum_q   <= '0;
                  cout_q  <= 1'b0;
                  ovf_q   <= 1'b0;
               end
            end
            RUN: begin
               for (int unsigned j = 0; j < N; j++) begin
                  if (k_q == KW'(j)) sum_q[j*CHUNK +: CHUNK] <= s_c;
               end
               carry_q <= cy;
               k_q     <= k_q + KW'(1);
               if (last) begin
                  cout_q <= cy;
                  ovf_q  <= cy ^ cy_msb;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_seq_chunk_adder.sv
// Scoreboard bench for seq_chunk_adder: an 8-bit/4-bit instance for directed scenarios
// and three 32-bit instances (CHUNK 4, 8, 32) driven in lockstep for the random sweep.
module tb_seq_chunk_adder;
   typedef struct packed {
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
   } exp_t;

   logic clock = 1'b0;
   logic reset;
   int   vectors = 0;
   int   miscompares = 0;
   exp_t q8[$];
   exp_t q32[$];

   always #10 clock = ~clock;

   seq_chunk_adder_if #(.WIDTH(8))  if8 ();
   seq_chunk_adder_if #(.WIDTH(32)) ifa ();
   seq_chunk_adder_if #(.WIDTH(32)) ifb ();
   seq_chunk_adder_if #(.WIDTH(32)) ifc ();

   seq_chunk_adder #(.WIDTH(8),  .CHUNK(4))  dut8   (.clock(clock), .reset(reset), .bus(if8.slave));
   seq_chunk_adder #(.WIDTH(32), .CHUNK(4))  dut_c4 (.clock(clock), .reset(reset), .bus(ifa.slave));
   seq_chunk_adder #(.WIDTH(32), .CHUNK(8))  dut_c8 (.clock(clock), .reset(reset), .bus(ifb.slave));
   seq_chunk_adder #(.WIDTH(32), .CHUNK(32)) dut_c32(.clock(clock), .reset(reset), .bus(ifc.slave));

   // Reference from true unsigned and signed arithmetic in 64 bits.
   function automatic exp_t model(input logic [31:0] a, b, input logic c, s, input int w);
      longint mask = (longint'(1) << w) - 1;
      longint ua = longint'(a) & mask;
      longint ub = longint'(b) & mask;
      longint sa = a[w-1] ? ua - (mask + 1) : ua;
      longint sb = b[w-1] ? ub - (mask + 1) : ub;
      longint u, v;
      exp_t   e;
      if (s) begin
         u = ua - ub - longint'(c);
         v = sa - sb - longint'(c);
         e.cout = (u >= 0);
      end else begin
         u = ua + ub + longint'(c);
         v = sa + sb + longint'(c);
         e.cout = (u > mask);
      end
      e.sum = 32'(u & mask);
      e.ovf = (v > (mask >> 1)) || (v < -((mask >> 1) + 1));
      return e;
   endfunction

   task automatic offer8(input logic [7:0] a, b, input logic c, s);
      if8.in_a = a; if8.in_b = b; if8.cin = c; if8.sub = s; if8.in_valid = 1'b1;
      @(posedge clock);
      @(negedge clock);
      if8.in_valid = 1'b0;
   endtask

   task automatic collect8(output exp_t got, output int lat);
      lat = 0;
      while (if8.out_valid !== 1'b1 && lat < 40) begin
         @(negedge clock);
         lat++;
      end
      if (lat >= 40) lat = -1;
      got.sum  = {24'h0, if8.sum};
      got.cout = if8.cout;
      got.ovf  = if8.ovf;
      if (if8.out_ready === 1'b1) @(negedge clock);
   endtask

   task automatic test_reset;
      logic seen;
      reset = 1'b1;
      if8.in_a = 8'h01; if8.in_b = 8'h01; if8.cin = 1'b0; if8.sub = 1'b0; if8.in_valid = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      if8.in_valid = 1'b0;
      vectors++; if (if8.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", if8.in_ready); end
      vectors++; if (if8.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", if8.out_valid); end
      vectors++; if (if8.sum !== 8'h00) begin miscompares++; $display("FAIL reset_sum: got %h want 00", if8.sum); end
      vectors++; if ({if8.cout, if8.ovf} !== 2'b00) begin miscompares++; $display("FAIL reset_flags: got %b want 00", {if8.cout, if8.ovf}); end
      vectors++; if ({ifa.in_ready, ifb.in_ready, ifc.in_ready} !== 3'b111) begin
         miscompares++; $display("FAIL reset_in_ready32: got %b want 111", {ifa.in_ready, ifb.in_ready, ifc.in_ready}); end
      seen = 1'b0;
      repeat (4) begin
         @(negedge clock);
         if (if8.out_valid !== 1'b0 || if8.in_ready !== 1'b1) seen = 1'b1;
      end
      vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL reset_dropped_handshake: got activity %b want 0", seen); end
   endtask

   task automatic test_add_wrap;
      logic [7:0] ta[3] = '{8'h3D, 8'hFF, 8'h7F};
      logic [7:0] tb_[3] = '{8'h28, 8'h01, 8'h01};
      logic       tc[3] = '{1'b1, 1'b0, 1'b0};
      logic [7:0] es[3] = '{8'h66, 8'h00, 8'h80};
      logic       ec[3] = '{1'b0, 1'b1, 1'b0};
      logic       eo[3] = '{1'b0, 1'b0, 1'b1};
      exp_t got, e;
      int   lat;
      for (int i = 0; i < 3; i++) begin
         q8.push_back(exp_t'({24'h0, es[i], ec[i], eo[i]}));
         offer8(ta[i], tb_[i], tc[i], 1'b0);
         if8.in_a = 8'hA5; if8.in_b = 8'h5A; if8.sub = 1'b1;
         collect8(got, lat);
         e = q8.pop_front();
         vectors++; if (lat !== 2) begin miscompares++; $display("FAIL add_latency[%0d]: got %0d want 2", i, lat); end
         vectors++; if (got.sum !== e.sum) begin miscompares++; $display("FAIL add_sum[%0d]: got %h want %h", i, got.sum, e.sum); end
         vectors++; if (got.cout !== e.cout) begin miscompares++; $display("FAIL add_cout[%0d]: got %b want %b", i, got.cout, e.cout); end
         vectors++; if (got.ovf !== e.ovf) begin miscompares++; $display("FAIL add_ovf[%0d]: got %b want %b", i, got.ovf, e.ovf); end
      end
   endtask

   task automatic test_subtract;
      logic [7:0] ta[3] = '{8'h05, 8'h80, 8'h10};
      logic [7:0] tb_[3] = '{8'h07, 8'h01, 8'h05};
      logic       tc[3] = '{1'b0, 1'b0, 1'b1};
      logic [7:0] es[3] = '{8'hFE, 8'h7F, 8'h0A};
      logic       ec[3] = '{1'b0, 1'b1, 1'b1};
      logic       eo[3] = '{1'b0, 1'b1, 1'b0};
      exp_t got, e;
      int   lat;
      for (int i = 0; i < 3; i++) begin
         q8.push_back(exp_t'({24'h0, es[i], ec[i], eo[i]}));
         offer8(ta[i], tb_[i], tc[i], 1'b1);
         if8.sub = 1'b0; if8.cin = ~tc[i];
         collect8(got, lat);
         e = q8.pop_front();
         vectors++; if (lat !== 2) begin miscompares++; $display("FAIL sub_latency[%0d]: got %0d want 2", i, lat); end
         vectors++; if (got.sum !== e.sum) begin miscompares++; $display("FAIL sub_sum[%0d]: got %h want %h", i, got.sum, e.sum); end
         vectors++; if (got.cout !== e.cout) begin miscompares++; $display("FAIL sub_cout[%0d]: got %b want %b", i, got.cout, e.cout); end
         vectors++; if (got.ovf !== e.ovf) begin miscompares++; $display("FAIL sub_ovf[%0d]: got %b want %b", i, got.ovf, e.ovf); end
      end
   endtask

   task automatic test_backpressure;
      exp_t got, e;
      int   lat;
      if8.out_ready = 1'b0;
      q8.push_back('{sum: 32'h33, cout: 1'b0, ovf: 1'b0});
      offer8(8'h11, 8'h22, 1'b0, 1'b0);
      collect8(got, lat);
      e = q8.pop_front();
      vectors++; if (lat !== 2) begin miscompares++; $display("FAIL bp_latency: got %0d want 2", lat); end
      vectors++; if (got.sum !== e.sum) begin miscompares++; $display("FAIL bp_sum: got %h want %h", got.sum, e.sum); end
      if8.in_a = 8'h40; if8.in_b = 8'h05; if8.cin = 1'b0; if8.sub = 1'b0; if8.in_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clock);
         vectors++; if (if8.out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", c, if8.out_valid); end
         vectors++; if (if8.in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready[%0d]: got %b want 0", c, if8.in_ready); end
         vectors++; if (if8.sum !== 8'h33) begin miscompares++; $display("FAIL bp_sum_stable[%0d]: got %h want 33", c, if8.sum); end
      end
      if8.out_ready = 1'b1;
      q8.push_back('{sum: 32'h45, cout: 1'b0, ovf: 1'b0});
      @(negedge clock);
      vectors++; if ({if8.in_ready, if8.out_valid} !== 2'b10) begin
         miscompares++; $display("FAIL bp_release: got ready/valid %b want 10", {if8.in_ready, if8.out_valid}); end
      @(negedge clock);
      if8.in_valid = 1'b0;
      collect8(got, lat);
      e = q8.pop_front();
      vectors++; if (lat !== 2) begin miscompares++; $display("FAIL bp_next_latency: got %0d want 2", lat); end
      vectors++; if (got.sum !== e.sum) begin miscompares++; $display("FAIL bp_next_sum: got %h want %h", got.sum, e.sum); end
   endtask

   task automatic test_reset_mid;
      exp_t got, e;
      int   lat;
      logic seen;
      if8.in_a = 8'h99; if8.in_b = 8'h11; if8.cin = 1'b0; if8.sub = 1'b0; if8.in_valid = 1'b1;
      @(posedge clock);
      @(negedge clock);
      if8.in_valid = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      vectors++; if (if8.out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_out_valid: got %b want 0", if8.out_valid); end
      vectors++; if (if8.sum !== 8'h00) begin miscompares++; $display("FAIL mid_sum: got %h want 00", if8.sum); end
      vectors++; if (if8.in_ready !== 1'b1) begin miscompares++; $display("FAIL mid_in_ready: got %b want 1", if8.in_ready); end
      seen = 1'b0;
      repeat (3) begin
         @(negedge clock);
         if (if8.out_valid !== 1'b0) seen = 1'b1;
      end
      vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL mid_aborted: got result %b want 0", seen); end
      q8.push_back('{sum: 32'h46, cout: 1'b0, ovf: 1'b0});
      offer8(8'h12, 8'h34, 1'b0, 1'b0);
      collect8(got, lat);
      e = q8.pop_front();
      vectors++; if (lat !== 2) begin miscompares++; $display("FAIL mid_next_latency: got %0d want 2", lat); end
      vectors++; if (got.sum !== e.sum) begin miscompares++; $display("FAIL mid_next_sum: got %h want %h", got.sum, e.sum); end
   endtask

   task automatic test_back_to_back;
      exp_t got, e;
      int   lat, idx;
      logic [7:0] a, b;
      logic c, s;
      for (int n = 0; n < 30; n++) begin
         a = 8'($urandom); b = 8'($urandom);
         c = 1'($urandom_range(0, 1)); s = 1'($urandom_range(0, 1));
         if8.in_a = a; if8.in_b = b; if8.cin = c; if8.sub = s; if8.in_valid = 1'b1;
         q8.push_back(model({24'h0, a}, {24'h0, b}, c, s, 8));
         @(posedge clock);
         @(negedge clock);
         idx = 0; lat = -1; got = '0;
         while (if8.in_ready !== 1'b1 && idx < 40) begin
            if (if8.out_valid === 1'b1) begin
               lat = idx;
               got.sum = {24'h0, if8.sum}; got.cout = if8.cout; got.ovf = if8.ovf;
            end
            if8.in_a = 8'($urandom); if8.in_b = 8'($urandom);
            @(negedge clock);
            idx++;
         end
         e = q8.pop_front();
         vectors++; if (lat !== 2) begin miscompares++; $display("FAIL b2b_latency[%0d]: got %0d want 2", n, lat); end
         vectors++; if (idx !== 3) begin miscompares++; $display("FAIL b2b_ready_gap[%0d]: got %0d want 3", n, idx); end
         vectors++; if (got.sum !== e.sum) begin miscompares++; $display("FAIL b2b_sum[%0d]: got %h want %h", n, got.sum, e.sum); end
         vectors++; if ({got.cout, got.ovf} !== {e.cout, e.ovf}) begin
            miscompares++; $display("FAIL b2b_flags[%0d]: got %b want %b", n, {got.cout, got.ovf}, {e.cout, e.ovf}); end
      end
      if8.in_valid = 1'b0;
   endtask

   task automatic test_sweep;
      int          lat_want[3] = '{8, 4, 1};
      int          chunk_of[3] = '{4, 8, 32};
      logic        done[3];
      logic        ov[3], co[3], of[3];
      logic [31:0] sm[3];
      logic [31:0] a, b;
      logic        c, s;
      int          idx, w;
      exp_t        e;
      for (int n = 0; n < 1000; n++) begin
         a = $urandom; b = $urandom;
         c = 1'($urandom_range(0, 1)); s = 1'($urandom_range(0, 1));
         case (n)
            0: begin a = 32'hFFFF_FFFF; b = 32'h1; c = 1'b0; s = 1'b0; end
            1: begin a = 32'h7FFF_FFFF; b = 32'h1; c = 1'b0; s = 1'b0; end
            2: begin a = 32'h8000_0000; b = 32'h1; c = 1'b0; s = 1'b1; end
            3: begin a = 32'h0;         b = 32'h0; c = 1'b1; s = 1'b1; end
            default: ;
         endcase
         w = 0;
         while (!(ifa.in_ready === 1'b1 && ifb.in_ready === 1'b1 && ifc.in_ready === 1'b1) && w < 40) begin
            @(negedge clock);
            w++;
         end
         if (w >= 40) begin
            vectors++; miscompares++;
            $display("FAIL sweep_idle_timeout[%0d]: got busy want idle", n);
            break;
         end
         ifa.in_a = a; ifa.in_b = b; ifa.cin = c; ifa.sub = s; ifa.in_valid = 1'b1;
         ifb.in_a = a; ifb.in_b = b; ifb.cin = c; ifb.sub = s; ifb.in_valid = 1'b1;
         ifc.in_a = a; ifc.in_b = b; ifc.cin = c; ifc.sub = s; ifc.in_valid = 1'b1;
         q32.push_back(model(a, b, c, s, 32));
         @(posedge clock);
         @(negedge clock);
         ifa.in_valid = 1'b0; ifb.in_valid = 1'b0; ifc.in_valid = 1'b0;
         e = q32[0];
         done = '{1'b0, 1'b0, 1'b0};
         idx = 0;
         while (!(done[0] && done[1] && done[2]) && idx < 40) begin
            ov = '{ifa.out_valid, ifb.out_valid, ifc.out_valid};
            sm = '{ifa.sum, ifb.sum, ifc.sum};
            co = '{ifa.cout, ifb.cout, ifc.cout};
            of = '{ifa.ovf, ifb.ovf, ifc.ovf};
            for (int i = 0; i < 3; i++) begin
               if (!done[i] && ov[i] === 1'b1) begin
                  done[i] = 1'b1;
                  vectors++; if (idx !== lat_want[i]) begin miscompares++;
                     $display("FAIL sweep_latency c%0d[%0d]: got %0d want %0d", chunk_of[i], n, idx, lat_want[i]); end
                  vectors++; if (sm[i] !== e.sum) begin miscompares++;
                     $display("FAIL sweep_sum c%0d[%0d]: got %h want %h", chunk_of[i], n, sm[i], e.sum); end
                  vectors++; if (co[i] !== e.cout) begin miscompares++;
                     $display("FAIL sweep_cout c%0d[%0d]: got %b want %b", chunk_of[i], n, co[i], e.cout); end
                  vectors++; if (of[i] !== e.ovf) begin miscompares++;
                     $display("FAIL sweep_ovf c%0d[%0d]: got %b want %b", chunk_of[i], n, of[i], e.ovf); end
               end
            end
            if (!(done[0] && done[1] && done[2])) begin
               @(negedge clock);
               idx++;
            end
         end
         void'(q32.pop_front());
         for (int i = 0; i < 3; i++) begin
            if (!done[i]) begin
               vectors++; miscompares++;
               $display("FAIL sweep_timeout c%0d[%0d]: got no out_valid want one", chunk_of[i], n);
            end
         end
      end
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: got no finish want finish by 2ms");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1;
      if8.in_valid = 1'b0; if8.out_ready = 1'b1; if8.in_a = '0; if8.in_b = '0; if8.cin = 1'b0; if8.sub = 1'b0;
      ifa.in_valid = 1'b0; ifa.out_ready = 1'b1; ifa.in_a = '0; ifa.in_b = '0; ifa.cin = 1'b0; ifa.sub = 1'b0;
      ifb.in_valid = 1'b0; ifb.out_ready = 1'b1; ifb.in_a = '0; ifb.in_b = '0; ifb.cin = 1'b0; ifb.sub = 1'b0;
      ifc.in_valid = 1'b0; ifc.out_ready = 1'b1; ifc.in_a = '0; ifc.in_b = '0; ifc.cin = 1'b0; ifc.sub = 1'b0;
      test_reset();
      test_add_wrap();
      test_subtract();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      test_sweep();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
